// File: rtl/ps2_kbd_responder.sv
// rtl/ps2_kbd_responder.sv - PS/2 keyboard receiver with scan-code FIFO and xkey status word
// Optional PS2_BREAK_MERGE_EN folds 0xF0 prefixes into the brk flag of the next entry.
module ps2_kbd_responder #(
    parameter int DEPTH      = 8,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        kbd_rd,
    output logic [15:0] xkey,
    output logic        rx_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;

    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic          push_q, push_d;
    logic [7:0]    push_code_q, push_code_d;
    logic          push_brk_q, push_brk_d;
    logic          err_set;
`ifdef PS2_BREAK_MERGE_EN
    logic          pend_q, pend_d;
`endif

    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d, err_q, err_d;
    logic          ready, full, pop, do_push, ovf_set;
    logic [8:0]    head;
    logic [3:0]    cnt_sat;

    // Glitch filter: follow the synchronised clock only after it has held a new level long enough.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
            else                               fcnt_d = fcnt_q + FW'(1);
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        to_d        = to_q;
        push_d      = 1'b0;
        push_code_d = push_code_q;
        push_brk_d  = push_brk_q;
        err_set     = 1'b0;
`ifdef PS2_BREAK_MERGE_EN
        pend_d      = pend_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall && !dat_s2_q) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
            end
            default: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (((^shift_q) ^ par_q) && dat_s2_q) begin
                        push_code_d = shift_q;
`ifdef PS2_BREAK_MERGE_EN
                        if (shift_q == 8'hF0) begin
                            pend_d = 1'b1;
                        end else begin
                            push_d     = 1'b1;
                            push_brk_d = pend_q;
                            pend_d     = 1'b0;
                        end
`else
                        push_d     = 1'b1;
                        push_brk_d = 1'b0;
`endif
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
        endcase
        // Stalled partial frames are abandoned silently.
        if (state_q == ST_IDLE || fall) begin
            to_d = '0;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
            to_d    = '0;
            state_d = ST_IDLE;
`ifdef PS2_BREAK_MERGE_EN
            pend_d  = 1'b0;
`endif
        end else begin
            to_d = to_q + TW'(1);
        end
    end

    always_comb begin
        ready   = (cnt_q != 5'd0);
        full    = (cnt_q == 5'(DEPTH));
        pop     = kbd_rd & ready;
        do_push = push_q & (~full | pop);
        ovf_set = push_q & full & ~pop;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_ptr_q] = {push_brk_q, push_code_q};
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !pop)      cnt_d = cnt_q + 5'd1;
        else if (!do_push && pop) cnt_d = cnt_q - 5'd1;
        // A set event in the read cycle beats the read-clear.
        ovf_d = ovf_set | (ovf_q & ~kbd_rd);
        err_d = err_set | (err_q & ~kbd_rd);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= ST_IDLE;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_q        <= '0;
            push_q      <= 1'b0;
            push_code_q <= 8'h00;
            push_brk_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= 5'd0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef PS2_BREAK_MERGE_EN
            pend_q      <= 1'b0;
`endif
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_q        <= to_d;
            push_q      <= push_d;
            push_code_q <= push_code_d;
            push_brk_q  <= push_brk_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
`ifdef PS2_BREAK_MERGE_EN
            pend_q      <= pend_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head    = ready ? mem_q[rd_ptr_q] : 9'h000;
    assign cnt_sat = (cnt_q > 5'd15) ? 4'hF : cnt_q[3:0];
    assign xkey    = {ready, ovf_q, err_q, head[8], cnt_sat, head[7:0]};
    assign rx_busy = (state_q != ST_IDLE);
endmodule

// File: doc/ps2_kbd_responder.md
Name: ps2_kbd_responder

Overview:
- Keyboard-side responder for the 0xD bus read region.
- Deserialises PS/2 device-to-host frames and buffers completed scan codes in a small FIFO.
- Presents the FIFO head plus status on the 16-bit xkey word that the bus zero-extends to Cpu_data4bus.
- Pops one entry per CPU read strobe. Fully synchronous to the CPU clock.

Parameters:
- DEPTH, 8: FIFO entries; power of 2, from 2 to 16.
- FILTER_LEN, 8: clk cycles the synchronised ps2_clk must hold a new level before the filtered clock follows it.
- TIMEOUT, 50000: clk cycles without a filtered falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- kbd_rd  in  1  one-cycle pop strobe, driven high when the CPU reads region 0xD
- xkey  out  16  status and head word
  - [15] ready (FIFO not empty)
  - [14] overflow, sticky
  - [13] err, sticky (parity or stop-bit fault)
  - [12] brk (see optional feature)
  - [11:8] count, saturating at 15
  - [7:0] head code, 0x00 when empty
- rx_busy  out  1  frame receiver not in IDLE

Behaviour:
- Reset (rst=0 at a clk edge):
  - FIFO pointers, count, overflow and err cleared; FSM to IDLE; timeout counter cleared.
  - Filtered clock and both sync flops set to 1.
  - xkey=0x0000, rx_busy=0.
  - A frame in flight when reset is applied is discarded.
- Input conditioning:
  - ps2_clk and ps2_data each pass through 2 flip-flops.
  - Filtered clock changes level only after the synchronised clock differs from it for FILTER_LEN consecutive cycles.
  - fall = filtered clock goes 1 to 0; fall is a one-cycle pulse.
  - ps2_data is sampled, already synchronised, in the fall cycle.
- Receiver FSM. All transitions occur only on fall unless noted.
  - IDLE: sampled data 0 goes to DATA with bit index 0; data 1 stays in IDLE.
  - DATA: shift bits in LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: evaluate and return to IDLE.
    - Frame good when the XOR of the 8 data bits and the parity bit is 1 (odd parity) and the stop bit is 1. A good frame raises push for one cycle on the next clk.
    - Otherwise no push, and err is set.
  - Timeout: in any state other than IDLE, a counter increments each cycle and clears on fall. On reaching TIMEOUT the FSM goes to IDLE and no flag is set.
- FIFO behaviour:
  - Entry is {brk, code}, 9 bits.
  - Head is combinational from the read pointer. The code is visible in xkey 2 cycles after the stop-bit fall.
  - pop = kbd_rd & ready.
  - Push when full without pop: entry dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle: both performed, count unchanged, no overflow, including when full.
  - Pop when empty: no pointer change.
  - Pointers wrap modulo DEPTH. count is the stored entry count.
- Sticky flags:
  - Any kbd_rd cycle clears overflow and err, empty or not.
  - A set event in the same cycle as kbd_rd wins, so the flag stays 1.
- kbd_rd held high for N cycles pops up to N entries; the bus must pulse it for one cycle per read.

Optional Feature:
- Macro: PS2_BREAK_MERGE_EN.
- Defined:
  - A good frame with code 0xF0 is not pushed; it sets a pending-break register.
  - The next good frame is pushed with brk=1, and pending is cleared.
  - Pending is cleared by reset and by a timeout. It is not cleared by err frames.
  - A second consecutive 0xF0 keeps pending set.
- Undefined:
  - 0xF0 is pushed as an ordinary entry.
  - brk is always 0.
  - No pending register exists.

Test Plan:
- Reset, then idle lines at 1 -> xkey=0x0000, rx_busy=0. Send frame 0x1C with parity 0 and stop 1 -> xkey=0x811C. Pulse kbd_rd once -> xkey=0x0000.
- Send 0x1C with parity 1 -> no push, xkey=0x2000. Pulse kbd_rd -> xkey=0x0000.
- DEPTH=8: send codes 0x01 to 0x09 without reads -> xkey=0xC801 (ready, overflow, count 8, head 0x01). Pop 8 times -> codes 0x01 to 0x08 in order, then xkey=0x0000.
- With FIFO full, kbd_rd coincides with the push cycle of a 9th code -> count stays 8, overflow stays 0, and the last entry equals the new code.
- Send 3 data bits then stop toggling ps2_clk for TIMEOUT+10 cycles -> rx_busy falls, no push, no flag set. Next full frame 0x32 is received correctly.
- Send 0xF0 then 0x1C:
  - PS2_BREAK_MERGE_EN defined -> single entry, xkey=0x911C.
  - Undefined -> xkey=0x82F0, then after one pop 0x811C.
